instr_fetch_unit: RTL and testbench

Requester side of the instruction memory read port: owns the fetch PC, drives the word address into the combinational instruction memory, and buffers returned words with their PCs in a small FIFO toward decode. Sustains one instruction per cycle when the consumer is ready. Accepts redirects (branch/jump) that flush buffered instructions and restart fetch at a new PC.

---
 rtl/instr_fetch_unit.sv | 131 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Requester side of the instruction memory read port. Owns the fetch PC,
//   presents it as the byte address to a combinational instruction memory,
//   and buffers the returned words together with their PCs in a small FIFO
//   toward decode. Sustains one instruction per cycle when the consumer is
//   ready; a redirect flushes the FIFO and restarts fetch at a new PC.
//
// Parameters
//   RESET_PC  fetch PC loaded on reset
//   Q_DEPTH   FIFO entries (power of two, 2..16)
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   fetch_en          1 = fetching allowed; 0 = no enqueue, PC holds
//   redirect_valid    flush the FIFO and restart at redirect_pc
//   redirect_pc       new fetch PC (bits [1:0] forced to 0)
//   imem_addr         byte address to instruction memory (registered)
//   imem_data         instruction word for imem_addr, same cycle
//   out_valid/ready   FIFO head handshake toward decode
//   out_instr, out_pc head instruction word and its byte PC
//
// Optional feature (macro IFU_PERF_CNT_EN)
//   perf_fetch_cnt    +1 per enqueue
//   perf_stall_cnt    +1 per cycle with fetch_en, FIFO full and no dequeue
//   Both clear on rst only and wrap at 2^32.

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned Q_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int unsigned PW = $clog2(Q_DEPTH);
    localparam logic [PW:0] DEPTH_C = Q_DEPTH[PW:0];

    logic [31:0]   fetch_pc;
    logic [31:0]   pc_q    [Q_DEPTH];
    logic [31:0]   instr_q [Q_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;

    logic deq;
    logic enq;

    assign imem_addr = fetch_pc;
    assign out_valid = (count != '0);
    // When empty the head slot still holds a stale (or reset-cleared) entry,
    // so these never go X after reset.
    assign out_instr = instr_q[rd_ptr];
    assign out_pc    = pc_q[rd_ptr];

    assign deq = out_valid && out_ready;
    // A full FIFO may still accept when the head leaves in the same cycle.
    assign enq = fetch_en && !redirect_valid && ((count < DEPTH_C) || deq);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int unsigned i = 0; i < Q_DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (redirect_valid) begin
            // Any head handshake this cycle is simply absorbed by the flush:
            // the consumer already took the entry.
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (enq) begin
                pc_q[wr_ptr]    <= fetch_pc;
                instr_q[wr_ptr] <= imem_data;
                wr_ptr          <= wr_ptr + 1'b1;
                fetch_pc        <= fetch_pc + 32'd4;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic stall;

    assign stall = fetch_en && (count == DEPTH_C) && !deq;

    // Kept separate from the FIFO state so a redirect never clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (enq) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (stall) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    // Memory model: the word at each address is its word index.
    assign imem_data = imem_addr >> 2;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .Q_DEPTH  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = pc >> 2;
        sb.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Every head handshake is scored against the next expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("hs_pc", out_pc, e.pc);
                check("hs_instr", out_instr, e.instr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        fetch_en       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        tick();
        tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_instr", out_instr, 32'h0);

        // Streaming: one instruction per cycle, 1-cycle fill latency.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) expect_pc(32'(i * 4));
        rst = 1'b0;
        check("fill_not_yet", {31'd0, out_valid}, 32'd0);
        tick();
        check("fill_valid", {31'd0, out_valid}, 32'd1);
        check("fill_pc", out_pc, 32'h0);
        for (int i = 0; i < 8; i++) tick();
        check("stream_drained", 32'(sb.size()), 32'd0);

        // Back-pressure: queue fills to 4, fetch address freezes.
        rst       = 1'b1;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k >= 4) check("stall_addr", imem_addr, 32'h10);
        end
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_head", out_pc, 32'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) expect_pc(32'(i * 4));
        for (int i = 0; i < 8; i++) tick();
        out_ready = 1'b0;
        check("release_drained", 32'(sb.size()), 32'd0);

        // Redirect while full with a simultaneous head handshake.
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        expect_pc(32'h20);
        tick();
        redirect_valid = 1'b0;
        check("redir_flush_valid", {31'd0, out_valid}, 32'd0);
        check("redir_addr", imem_addr, 32'h40);
        expect_pc(32'h40);
        expect_pc(32'h44);
        tick();
        check("redir_valid", {31'd0, out_valid}, 32'd1);
        check("redir_pc", out_pc, 32'h40);
        check("redir_instr", out_instr, 32'h10);
        tick();

        // Reset together with redirect mid-stream: reset wins.
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        check("rstredir_valid", {31'd0, out_valid}, 32'd0);
        check("rstredir_addr", imem_addr, 32'h0);
        check("rstredir_pc", out_pc, 32'h0);
        check("rstredir_instr", out_instr, 32'h0);
        check("rstredir_drained", 32'(sb.size()), 32'd0);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        expect_pc(32'h0);
        expect_pc(32'h4);
        tick();
        check("restart_pc", out_pc, 32'h0);
        tick();
        tick();
        out_ready = 1'b0;

        // Redirect near the top of the address space: PC wraps to 0.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        check("wrap_flush_valid", {31'd0, out_valid}, 32'd0);
        check("wrap_addr", imem_addr, 32'hFFFF_FFF8);
        expect_pc(32'hFFFF_FFF8);
        expect_pc(32'hFFFF_FFFC);
        expect_pc(32'h0);
        expect_pc(32'h4);
        tick();
        check("wrap_first_pc", out_pc, 32'hFFFF_FFF8);
        for (int i = 0; i < 4; i++) tick();
        out_ready = 1'b0;
        check("wrap_drained", 32'(sb.size()), 32'd0);

        // fetch_en low: dequeues continue, PC holds.
        fetch_en  = 1'b0;
        out_ready = 1'b1;
        expect_pc(32'h8);
        tick();
        tick();
        check("noen_addr", imem_addr, 32'hC);
        check("noen_valid", {31'd0, out_valid}, 32'd0);
        check("noen_drained", 32'(sb.size()), 32'd0);

`ifdef IFU_PERF_CNT_EN
        // 6 fetches (two consumed, four queued) then 5 full-stall cycles.
        rst       = 1'b1;
        fetch_en  = 1'b1;
        out_ready = 1'b0;
        tick();
        tick();
        check("perf_rst_fetch", perf_fetch_cnt, 32'd0);
        check("perf_rst_stall", perf_stall_cnt, 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        expect_pc(32'h0);
        expect_pc(32'h4);
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("perf_fetch", perf_fetch_cnt, 32'd6);
        check("perf_stall", perf_stall_cnt, 32'd5);
        check("perf_drained", 32'(sb.size()), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
